// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial instruction memory loader with per-word read-back verify
//
// Accepts 32-bit instruction words on a valid/ready input, writes each one
// little-endian, one byte per cycle, starting at a latched base address, then
// reads the word back through the combinational 32-bit read port and compares.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a load (honoured only in IDLE, DONE or ERR)
//   base_addr         byte address of the first word, latched on start
//   word_count        number of words to load, latched on start
//   in_valid/in_data  instruction word source
//   in_ready          high while waiting for a word (LOAD)
//   mem_we            byte write strobe
//   mem_addr          byte write address
//   mem_wdata         byte write data
//   mem_raddr         word base address for read-back
//   mem_rword         combinational read data {m[a+3],m[a+2],m[a+1],m[a]}
//   busy              loader owns the memory (LOAD, WRITE, VERIFY)
//   done              load completed
//   err_code          00 none, 01 misaligned base, 10 range overflow, 11 verify mismatch
//   err_addr          word address that failed verify, otherwise 0

module imem_loader #(
  parameter int IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rword,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nx;

  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [15:0] idx_q;
  logic [31:0] word_q;
  logic [1:0]  byte_q;
  logic [1:0]  err_code_q;
  logic [31:0] err_addr_q;
  logic [31:0] addr_q;
  logic [31:0] raddr_q;

  logic        start_ok;
  logic [32:0] end_addr;
  logic [1:0]  start_err;
  logic        last_word;
  logic        verify_ok;
  logic [31:0] word_base;

  always_comb begin
    start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    // 33-bit sum so a base near 4 GiB cannot wrap past the range check.
    end_addr  = {1'b0, base_addr} + {15'd0, word_count, 2'b00};
    if (base_addr[1:0] != 2'b00) begin
      start_err = 2'b01;
    end else if (end_addr > 33'(IMEM_SIZE)) begin
      start_err = 2'b10;
    end else begin
      start_err = 2'b00;
    end
    last_word = (idx_q + 16'd1) == count_q;
    verify_ok = (mem_rword == word_q);
    word_base = base_q + {14'd0, idx_q, 2'b00};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (start_err != 2'b00) begin
            state_nx = S_ERR;
          end else if (word_count == 16'd0) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (byte_q == 2'd3) begin
          state_nx = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (!verify_ok) begin
          state_nx = S_ERR;
        end else if (last_word) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      err_code_q <= '0;
      err_addr_q <= '0;
      addr_q     <= '0;
      raddr_q    <= '0;
    end else begin
      if (start_ok) begin
        base_q     <= base_addr;
        count_q    <= word_count;
        idx_q      <= '0;
        err_code_q <= start_err;
        err_addr_q <= '0;
      end
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            word_q  <= in_data;
            byte_q  <= 2'd0;
            addr_q  <= word_base;
            raddr_q <= word_base;
          end
        end
        S_WRITE: begin
          byte_q <= byte_q + 2'd1;
          // Stop advancing on the last byte so mem_addr holds the final write address.
          if (byte_q != 2'd3) begin
            addr_q <= addr_q + 32'd1;
          end
        end
        S_VERIFY: begin
          if (verify_ok) begin
            idx_q <= idx_q + 16'd1;
          end else begin
            err_code_q <= 2'b11;
            err_addr_q <= raddr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_VERIFY: busy = 1'b1;
      S_DONE:   done = 1'b1;
      default: ;
    endcase
    mem_addr  = addr_q;
    mem_raddr = raddr_q;
    mem_wdata = word_q[{byte_q, 3'b000} +: 8];
    err_code  = err_code_q;
    err_addr  = err_addr_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a byte memory model
module tb_imem_loader;

  localparam int MEMSZ = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rword;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  imem_loader #(.IMEM_SIZE(MEMSZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rword  (mem_rword),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_writes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: write at the clock edge, combinational word read.
  logic [7:0] mem     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];
  logic       mem_clr = 1'b1;
  logic       stuck   = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < MEMSZ; k++) mem[k] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  function automatic logic [7:0] rd(input logic [9:0] a);
    return (stuck && a == 10'h1D) ? 8'h00 : mem[a];
  endfunction

  always_comb mem_rword = {rd(mem_raddr[9:0] + 10'd3), rd(mem_raddr[9:0] + 10'd2),
                           rd(mem_raddr[9:0] + 10'd1), rd(mem_raddr[9:0])};

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         mon_e;
  logic [31:0] words[$];
  int          gaps[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every byte write must match the next expected write in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        n_writes++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = sb_q.pop_front();
          chk("byte_write", {24'h0, mem_addr, mem_wdata}, {24'h0, mon_e.addr, mon_e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    ok = in_ready;
    if (!ok) chk("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Feeds words[] from base b; gaps[i] idle LOAD cycles precede word i.
  task automatic feed(input logic [31:0] b);
    bit ok;
    for (int i = 0; i < words.size(); i++) begin
      if (gaps[i] > 0) begin
        in_valid = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        for (int g = 0; g < gaps[i]; g++) begin
          // A start while busy must be ignored.
          start      = (g == 1);
          base_addr  = 32'h6;
          word_count = 16'd1;
          chk("gap_hold", {62'h0, in_ready, mem_we}, {62'h0, 1'b1, 1'b0});
          tick();
        end
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = words[i];
      wait_ready(ok);
      if (!ok) begin
        in_valid = 1'b0;
        return;
      end
      for (int k = 0; k < 4; k++) begin
        logic [31:0] a;
        a = b + 32'(4 * i + k);
        sb_q.push_back({a, words[i][8*k +: 8]});
        ref_mem[a[9:0]] = words[i][8*k +: 8];
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      tick();
      t++;
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_image(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < MEMSZ; k++) if (mem[k] !== ref_mem[k]) bad++;
    chk(name, 64'(bad), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic set_words(input int n, input int gap_at, input int gap_len);
    words.delete();
    gaps.delete();
    for (int i = 0; i < n; i++) begin
      words.push_back($urandom());
      gaps.push_back(i == gap_at ? gap_len : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w0, cnt, sumg, exp_err;
    logic [31:0] b;

    for (int k = 0; k < MEMSZ; k++) ref_mem[k] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {50'h0, in_ready, mem_we, busy, done, err_code, mem_wdata},
        64'h0);
    chk("rst_addr", {32'h0, mem_addr | mem_raddr | err_addr}, 64'h0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("idle_after_rst", {60'h0, in_ready, mem_we, busy, done}, 64'h0);

    // 3-word load, in_valid held high
    words = '{32'h00000000, 32'h00400093, 32'h00100113};
    gaps  = '{0, 0, 0};
    do_start(32'h0, 16'd3);
    t0 = cyc;
    chk("load_entry", {62'h0, busy, in_ready}, 64'h3);
    feed(32'h0);
    wait_idle();
    chk("done_latency_3w", 64'(cyc - t0), 64'd18);
    chk("done_3w", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
    chk_image("image_3w");

    // Same words with a 7-cycle source gap before the second word
    gaps = '{0, 7, 0};
    do_start(32'h0, 16'd3);
    t0 = cyc;
    feed(32'h0);
    wait_idle();
    chk("done_latency_gap", 64'(cyc - t0), 64'd25);
    chk("done_gap", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
    chk_image("image_gap");

    // Misaligned base
    w0 = n_writes;
    do_start(32'h6, 16'd1);
    chk("misaligned", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b0, 2'b01});
    repeat (3) tick();
    chk("misaligned_no_we", 64'(n_writes - w0), 64'd0);

    // Range boundary: exact fit
    set_words(1, -1, 0);
    do_start(32'd1020, 16'd1);
    feed(32'd1020);
    wait_idle();
    chk("range_fit", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
    chk_image("image_fit");

    // Range boundary: one word too many
    w0 = n_writes;
    do_start(32'd1020, 16'd2);
    chk("range_over", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b0, 2'b10});
    repeat (3) tick();
    chk("range_over_no_we", 64'(n_writes - w0), 64'd0);

    // Zero count
    do_start(32'h40, 16'd0);
    chk("count_zero", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b1, 2'b00});

    // Verify failure with byte 0x1D stuck at zero on read
    stuck = 1'b1;
    words = '{32'h0020C333};
    gaps  = '{0};
    do_start(32'h1C, 16'd1);
    feed(32'h1C);
    wait_idle();
    chk("verify_err", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b0, 2'b11});
    chk("verify_err_addr", {32'h0, err_addr}, 64'h1C);
    stuck = 1'b0;
    do_start(32'h1C, 16'd1);
    chk("restart_clears", {32'h0, err_addr, 28'h0, busy, done, err_code}, {64'h0} | 64'h8);
    feed(32'h1C);
    wait_idle();
    chk("restart_done", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
    chk_image("image_verify");

    // Reset during the third byte write
    set_words(1, -1, 0);
    do_start(32'h0, 16'd1);
    feed(32'h0);
    t0 = 0;
    while (!(mem_we && mem_addr == 32'd2) && t0 < 20) begin
      tick();
      t0++;
    end
    chk("reach_byte2", {63'h0, mem_we && mem_addr == 32'd2}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {50'h0, in_ready, mem_we, busy, done, err_code, mem_wdata}, 64'h0);
    chk("midrst_addr", {32'h0, mem_addr | mem_raddr | err_addr}, 64'h0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    set_words(1, -1, 0);
    do_start(32'h0, 16'd1);
    feed(32'h0);
    wait_idle();
    chk("after_rst_done", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
    chk_image("image_after_rst");

    // Randomized loads against the arithmetic reference
    for (int it = 0; it < 24; it++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      cnt = int'($urandom_range(0, 5));
      b   = 32'(4 * $urandom_range(0, 255));
      if (r == 0) b = b | 32'($urandom_range(1, 3));
      if (r == 1) begin
        b   = 32'(4 * $urandom_range(250, 255));
        cnt = (MEMSZ - int'(b)) / 4 + int'($urandom_range(0, 1));
      end
      if (b[1:0] != 2'b00) exp_err = 1;
      else if (int'(b) + 4 * cnt > MEMSZ) exp_err = 2;
      else exp_err = 0;

      w0 = n_writes;
      do_start(b, 16'(cnt));
      t0 = cyc;
      if (exp_err != 0) begin
        chk("rand_start_err", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b0, 2'(exp_err)});
        tick();
        chk("rand_err_no_we", 64'(n_writes - w0), 64'd0);
      end else if (cnt == 0) begin
        chk("rand_zero", {60'h0, busy, done, err_code}, {60'h0, 1'b0, 1'b1, 2'b00});
      end else begin
        words.delete();
        gaps.delete();
        sumg = 0;
        for (int i = 0; i < cnt; i++) begin
          int g;
          g = (i == 0) ? 0 : int'($urandom_range(0, 3));
          words.push_back($urandom());
          gaps.push_back(g);
          sumg += g;
        end
        feed(b);
        wait_idle();
        chk("rand_latency", 64'(cyc - t0), 64'(6 * cnt + sumg));
        chk("rand_done", {61'h0, done, err_code}, {61'h0, 1'b1, 2'b00});
        chk_image("rand_image");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
